// File: rtl/lcd_bus_writer_if.sv
// rtl/lcd_bus_writer_if.sv - upstream beat handshake between the lookup stage and the LCD bus writer
interface lcd_bus_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_dcx;
  logic       in_pause;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid, in_data, in_dcx, in_pause, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_dcx, in_pause, in_last,
    output in_ready
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - paced 8080-style LCD write bus driver; optional strobe counter under LCD_BUS_STATS_EN
module lcd_bus_writer #(
  parameter int SETUP_CYC   = 1,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic             clk,
  input  logic             nrst,
  lcd_bus_writer_if.slave  up,
  output logic [7:0]       lcd_d,
  output logic             lcd_dcx,
  output logic             lcd_wrx,
  output logic             lcd_csx,
  output logic             lcd_rdx,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      write_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] WR_LOW  = 2'd2;
  localparam logic [1:0] WR_HIGH = 2'd3;

  logic [1:0] state;
  logic [7:0] cnt;
  logic       accept;
  logic       last_accept;
  logic       strobe_done;

  assign up.in_ready   = (state == IDLE);
  assign busy          = (state != IDLE);
  assign lcd_rdx       = 1'b1;
  assign accept        = up.in_valid && (state == IDLE);
  assign last_accept   = accept && up.in_last;
  assign strobe_done   = (state == WR_LOW) && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      lcd_d      <= 8'h00;
      lcd_dcx    <= 1'b0;
      lcd_wrx    <= 1'b1;
      lcd_csx    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (last_accept) begin
            lcd_csx    <= 1'b1;
            frame_done <= 1'b1;
          end else if (accept && up.in_pause) begin
            lcd_csx <= 1'b1;
          end else if (accept) begin
            lcd_d   <= up.in_data;
            lcd_dcx <= up.in_dcx;
            lcd_csx <= 1'b0;
            cnt     <= 8'(SETUP_CYC - 1);
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            lcd_wrx <= 1'b0;
            cnt     <= 8'(WR_LOW_CYC - 1);
            state   <= WR_LOW;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WR_LOW: begin
          // Rising WRX here is the panel's latch point; data is still held.
          if (strobe_done) begin
            lcd_wrx <= 1'b1;
            cnt     <= 8'(WR_HIGH_CYC - 1);
            state   <= WR_HIGH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end

`ifdef LCD_BUS_STATS_EN
  logic [15:0] strobe_cnt;

  // Clear is taken on the last-beat edge so it lines up with the frame_done pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      strobe_cnt <= 16'h0000;
    end else if (last_accept) begin
      strobe_cnt <= 16'h0000;
    end else if (strobe_done) begin
      strobe_cnt <= strobe_cnt + 16'd1;
    end
  end

  assign write_count = strobe_cnt;
`else
  assign write_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb/tb_lcd_bus_writer.sv - scoreboard bench for lcd_bus_writer with randomized beats
module tb_lcd_bus_writer;
  localparam int S = 1;
  localparam int L = 2;
  localparam int H = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_writer_if up();
  lcd_bus_writer_if alt();

  logic [7:0]  lcd_d, alt_d;
  logic        lcd_dcx, lcd_wrx, lcd_csx, lcd_rdx, busy, frame_done;
  logic        alt_dcx, alt_wrx, alt_csx, alt_rdx, alt_busy, alt_fd;
  logic [15:0] write_count, alt_wc;

  lcd_bus_writer #(.SETUP_CYC(S), .WR_LOW_CYC(L), .WR_HIGH_CYC(H)) dut (
    .clk(clk), .nrst(nrst), .up(up),
    .lcd_d(lcd_d), .lcd_dcx(lcd_dcx), .lcd_wrx(lcd_wrx), .lcd_csx(lcd_csx),
    .lcd_rdx(lcd_rdx), .busy(busy), .frame_done(frame_done), .write_count(write_count)
  );

  lcd_bus_writer #(.SETUP_CYC(1), .WR_LOW_CYC(4), .WR_HIGH_CYC(1)) dut_alt (
    .clk(clk), .nrst(nrst), .up(alt),
    .lcd_d(alt_d), .lcd_dcx(alt_dcx), .lcd_wrx(alt_wrx), .lcd_csx(alt_csx),
    .lcd_rdx(alt_rdx), .busy(alt_busy), .frame_done(alt_fd), .write_count(alt_wc)
  );

  typedef struct {
    logic [7:0]  d;
    logic        dcx;
    logic [15:0] wc;
  } strobe_t;

  int checks = 0;
  int failures = 0;

  strobe_t    sq[$];
  logic [7:0] d_exp;
  logic       dcx_exp;
  logic       csx_exp;
  int         wc_model;
  int         fd_pending;
  bit         mon_en = 1'b0;
  logic       prev_wrx = 1'b1;
  logic       prev_fd = 1'b0;
  int         low_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wc_view(input int v);
`ifdef LCD_BUS_STATS_EN
    return 16'(v);
`else
    return 16'(v & 0);
`endif
  endfunction

  task automatic model_reset();
    d_exp      = 8'h00;
    dcx_exp    = 1'b0;
    csx_exp    = 1'b1;
    wc_model   = 0;
    fd_pending = 0;
    sq.delete();
  endtask

  // Monitor: pops the strobe scoreboard on each WRX rising edge, checks frame pulses.
  always @(negedge clk) begin
    strobe_t s;
    if (mon_en) begin
      chk("bus_hold", 32'({lcd_d, lcd_dcx, lcd_csx, lcd_rdx}), 32'({d_exp, dcx_exp, csx_exp, 1'b1}));
      if (lcd_wrx == 1'b0) low_run++;
      if (prev_wrx == 1'b0 && lcd_wrx == 1'b1) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", 32'(1), 32'(0));
        end else begin
          s = sq.pop_front();
          chk("strobe_data", 32'({lcd_d, lcd_dcx}), 32'({s.d, s.dcx}));
          chk("strobe_wc", 32'(write_count), 32'(s.wc));
          chk("wrx_low_width", 32'(low_run), 32'(L));
        end
        low_run = 0;
      end
      if (frame_done) begin
        chk("frame_expected", 32'(fd_pending > 0), 32'(1));
        if (fd_pending > 0) fd_pending--;
        chk("frame_single", 32'(prev_fd), 32'(0));
        chk("frame_wc", 32'(write_count), 32'(0));
      end
      prev_wrx = lcd_wrx;
      prev_fd  = frame_done;
    end else begin
      prev_wrx = 1'b1;
      prev_fd  = 1'b0;
      low_run  = 0;
    end
  end

  // Called #1 after a posedge or at a negedge; returns #1 after the accept edge (or ready return for writes).
  task automatic send(input logic [7:0] d, input logic dcx, input logic pause, input logic last);
    int n;
    up.in_valid = 1'b1;
    up.in_data  = d;
    up.in_dcx   = dcx;
    up.in_pause = pause;
    up.in_last  = last;
    n = 0;
    while (!up.in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(n), 32'(0));
        up.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    up.in_valid = 1'b0;
    if (last) begin
      csx_exp  = 1'b1;
      fd_pending++;
      wc_model = 0;
      chk("ready_after_last", 32'(up.in_ready), 32'(1));
    end else if (pause) begin
      csx_exp = 1'b1;
      chk("ready_after_pause", 32'(up.in_ready), 32'(1));
    end else begin
      strobe_t s;
      d_exp    = d;
      dcx_exp  = dcx;
      csx_exp  = 1'b0;
      wc_model = (wc_model + 1) % 65536;
      s.d = d; s.dcx = dcx; s.wc = wc_view(wc_model);
      sq.push_back(s);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!up.in_ready && n < 300);
      chk("ready_latency", 32'(n), 32'(1 + S + L + H));
    end
  endtask

  initial begin
    int n, lows;
    up.in_valid = 1'b0; up.in_data = 8'h00; up.in_dcx = 1'b0; up.in_pause = 1'b0; up.in_last = 1'b0;
    alt.in_valid = 1'b0; alt.in_data = 8'h00; alt.in_dcx = 1'b0; alt.in_pause = 1'b0; alt.in_last = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({lcd_d, lcd_dcx, lcd_wrx, lcd_csx, lcd_rdx, frame_done}), 32'({8'h00, 5'b01110}));
    chk("reset_ready_busy", 32'({up.in_ready, busy}), 32'(2'b10));
    chk("reset_wc", 32'(write_count), 32'(0));
    nrst = 1'b1;
    mon_en = 1'b1;

    send(8'h2A, 1'b0, 1'b0, 1'b0);
    send(8'h2C, 1'b0, 1'b0, 1'b0);
    send(8'h14, 1'b1, 1'b0, 1'b0);
    send(8'h99, 1'b0, 1'b1, 1'b0);
    send(8'h77, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        up.in_data = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if (kind < 7)      send(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      else if (kind < 9) send(8'($urandom), 1'($urandom), 1'b1, 1'b0);
      else               send(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    repeat (4) @(negedge clk);

    // Reset while WRX is low: the write is abandoned.
    up.in_valid = 1'b1; up.in_data = 8'h5E; up.in_dcx = 1'b1; up.in_pause = 1'b0; up.in_last = 1'b0;
    @(posedge clk);
    #1;
    up.in_valid = 1'b0;
    mon_en = 1'b0;
    n = 0;
    while (lcd_wrx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrx_low_seen", 32'(lcd_wrx), 32'(0));
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    chk("midreset_bus", 32'({lcd_d, lcd_wrx, lcd_csx}), 32'({8'h00, 2'b11}));
    chk("midreset_ready_busy", 32'({up.in_ready, busy}), 32'(2'b10));
    chk("midreset_wc", 32'(write_count), 32'(0));
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;
    send(8'hC3, 1'b0, 1'b0, 1'b0);

    // Alternate timing: WR_LOW_CYC=4, SETUP_CYC=1, WR_HIGH_CYC=1.
    @(posedge clk);
    #1;
    alt.in_valid = 1'b1; alt.in_data = 8'h5A; alt.in_dcx = 1'b1;
    chk("alt_ready_idle", 32'(alt.in_ready), 32'(1));
    @(posedge clk);
    #1;
    alt.in_data = 8'hA5; alt.in_dcx = 1'b0;
    n = 0; lows = 0;
    do begin
      @(negedge clk);
      n++;
      if (alt_wrx == 1'b0) lows++;
    end while (!alt.in_ready && n < 50);
    chk("alt_latency", 32'(n), 32'(7));
    chk("alt_low_width", 32'(lows), 32'(4));
    chk("alt_data", 32'({alt_d, alt_dcx}), 32'({8'h5A, 1'b1}));
    @(posedge clk);
    #1;
    alt.in_valid = 1'b0;
    chk("alt_second_data", 32'({alt_d, alt_dcx, alt_csx}), 32'({8'hA5, 2'b00}));
    repeat (10) @(negedge clk);

    chk("strobes_drained", 32'(sq.size()), 32'(0));
    chk("frames_drained", 32'(fd_pending), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
